pulse_gen: RTL

Parametrised square-wave voice for the APU, successor to the single-instance pulse channel. Registers are written through per-register strobes, replacing change detection. Quarter-frame and half-frame events arrive as clock enables, so the whole block runs on `apu_clk`. Adds sweep muting, envelope loop, a channel enable, and selectable sweep negate mode, so one RTL serves both APU pulse voices. Output is a signed sample feeding the APU mixer.

---
 rtl/pulse_gen_if.sv | 20 ++
 rtl/pulse_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_if.sv
// Register-write and frame-strobe bus into one pulse voice, plus the voice's sample outputs.
interface pulse_gen_if;
  logic              qtr_en;
  logic              hlf_en;
  logic [3:0]        wr_en;
  logic [7:0]        wr_data;
  logic              enable;
  logic signed [4:0] pulse_out;
  logic              active;

  modport master (
    output qtr_en, hlf_en, wr_en, wr_data, enable,
    input  pulse_out, active
  );

  modport slave (
    input  qtr_en, hlf_en, wr_en, wr_data, enable,
    output pulse_out, active
  );
endinterface

// File: rtl/pulse_gen.sv
// Square-wave APU voice: duty sequencer, envelope, length counter and frequency sweep,
// all on apu_clk with frame events arriving as clock enables.
module pulse_gen #(
  parameter bit          SWEEP_NEG_ONES = 1'b0,
  parameter logic [31:0] DUTY_TABLE     = 32'hF91E0602,
  parameter bit          LENGTH_EN      = 1'b1
) (
  input logic        apu_clk,
  input logic        rst,
  pulse_gen_if.slave pif
);

  // Register 0 fields
  logic [1:0]  duty_q, duty_d;
  logic        halt_q, halt_d;
  logic        const_q, const_d;
  logic [3:0]  vol_q, vol_d;
  // Register 1 fields
  logic        swp_en_q, swp_en_d;
  logic [2:0]  swp_per_q, swp_per_d;
  logic        negate_q, negate_d;
  logic [2:0]  shift_q, shift_d;
  // Timer / sequencer
  logic [10:0] period_q, period_d;
  logic [10:0] timer_q, timer_d;
  logic [2:0]  seq_q, seq_d;
  // Envelope
  logic        env_start_q, env_start_d;
  logic [3:0]  env_div_q, env_div_d;
  logic [3:0]  decay_q, decay_d;
  // Length and sweep
  logic [7:0]  length_q, length_d;
  logic [2:0]  swp_div_q, swp_div_d;
  logic        swp_reload_q, swp_reload_d;
  // Registered outputs
  logic [4:0]  pulse_q, pulse_d;
  logic        active_q, active_d;

  logic [10:0] change;
  logic [11:0] target;
  logic        mute;
  logic        len_nz;
  logic [3:0]  volume;
  logic        duty_bit;
  logic [4:0]  mag;
  logic [7:0]  len_load;
  logic [10:0] period_r3;

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    logic [7:0] val;
    case (idx)
      5'd0:  val = 8'h0A;
      5'd1:  val = 8'hFE;
      5'd2:  val = 8'h14;
      5'd3:  val = 8'h02;
      5'd4:  val = 8'h28;
      5'd5:  val = 8'h04;
      5'd6:  val = 8'h50;
      5'd7:  val = 8'h06;
      5'd8:  val = 8'hA0;
      5'd9:  val = 8'h08;
      5'd10: val = 8'h3C;
      5'd11: val = 8'h0A;
      5'd12: val = 8'h0E;
      5'd13: val = 8'h0C;
      5'd14: val = 8'h1A;
      5'd15: val = 8'h0E;
      5'd16: val = 8'h0C;
      5'd17: val = 8'h10;
      5'd18: val = 8'h18;
      5'd19: val = 8'h12;
      5'd20: val = 8'h30;
      5'd21: val = 8'h14;
      5'd22: val = 8'h60;
      5'd23: val = 8'h16;
      5'd24: val = 8'hC0;
      5'd25: val = 8'h18;
      5'd26: val = 8'h48;
      5'd27: val = 8'h1A;
      5'd28: val = 8'h10;
      5'd29: val = 8'h1C;
      5'd30: val = 8'h20;
      default: val = 8'h1E;
    endcase
    return val;
  endfunction

  // Sweep target and mute are evaluated continuously, not only on half-frames.
  always_comb begin
    change = period_q >> shift_q;
    if (negate_q) begin
      target = {1'b0, period_q} - {1'b0, change} - {11'd0, SWEEP_NEG_ONES};
    end else begin
      target = {1'b0, period_q} + {1'b0, change};
    end
    mute = (period_q < 11'd8) || (!negate_q && (target > 12'h7FF));
  end

  always_comb begin
    len_nz    = LENGTH_EN ? (length_q != 8'd0) : 1'b1;
    volume    = const_q ? vol_q : decay_q;
    duty_bit  = DUTY_TABLE[{duty_q, seq_q}];
    mag       = {1'b0, volume};
    len_load  = len_lookup(pif.wr_data[7:3]);
    period_r3 = {pif.wr_data[2:0], period_q[7:0]};
  end

  always_comb begin
    duty_d       = duty_q;
    halt_d       = halt_q;
    const_d      = const_q;
    vol_d        = vol_q;
    swp_en_d     = swp_en_q;
    swp_per_d    = swp_per_q;
    negate_d     = negate_q;
    shift_d      = shift_q;
    period_d     = period_q;
    timer_d      = timer_q;
    seq_d        = seq_q;
    env_start_d  = env_start_q;
    env_div_d    = env_div_q;
    decay_d      = decay_q;
    length_d     = length_q;
    swp_div_d    = swp_div_q;
    swp_reload_d = swp_reload_q;

    if (timer_q == 11'd0) begin
      timer_d = period_q;
      seq_d   = seq_q - 3'd1;
    end else begin
      timer_d = timer_q - 11'd1;
    end

    if (pif.qtr_en) begin
      if (env_start_q) begin
        env_start_d = 1'b0;
        decay_d     = 4'd15;
        env_div_d   = vol_q;
      end else if (env_div_q == 4'd0) begin
        env_div_d = vol_q;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (halt_q) begin
          decay_d = 4'd15;
        end
      end else begin
        env_div_d = env_div_q - 4'd1;
      end
    end

    if (pif.hlf_en) begin
      if (!halt_q && (length_q != 8'd0)) begin
        length_d = length_q - 8'd1;
      end
      if ((swp_div_q == 3'd0) && swp_en_q && (shift_q != 3'd0) && !mute) begin
        period_d = target[10:0];
      end
      if ((swp_div_q == 3'd0) || swp_reload_q) begin
        swp_div_d    = swp_per_q;
        swp_reload_d = 1'b0;
      end else begin
        swp_div_d = swp_div_q - 3'd1;
      end
    end

    // Register writes come last so they override any same-cycle counter activity.
    if (pif.wr_en[0]) begin
      duty_d  = pif.wr_data[7:6];
      halt_d  = pif.wr_data[5];
      const_d = pif.wr_data[4];
      vol_d   = pif.wr_data[3:0];
    end
    if (pif.wr_en[1]) begin
      swp_en_d     = pif.wr_data[7];
      swp_per_d    = pif.wr_data[6:4];
      negate_d     = pif.wr_data[3];
      shift_d      = pif.wr_data[2:0];
      swp_reload_d = 1'b1;
    end
    if (pif.wr_en[2]) begin
      period_d = {period_q[10:8], pif.wr_data};
    end
    if (pif.wr_en[3]) begin
      period_d    = period_r3;
      timer_d     = period_r3;
      seq_d       = 3'd0;
      env_start_d = 1'b1;
      if (pif.enable) begin
        length_d = len_load;
      end
    end

    if (!pif.enable) begin
      length_d = 8'd0;
    end
  end

  always_comb begin
    if (!len_nz || mute) begin
      pulse_d = 5'd0;
    end else if (duty_bit) begin
      pulse_d = mag;
    end else begin
      pulse_d = ~mag + 5'd1;
    end
    active_d = len_nz;
  end

  always_ff @(posedge apu_clk) begin
    if (rst) begin
      duty_q       <= '0;
      halt_q       <= 1'b0;
      const_q      <= 1'b0;
      vol_q        <= '0;
      swp_en_q     <= 1'b0;
      swp_per_q    <= '0;
      negate_q     <= 1'b0;
      shift_q      <= '0;
      period_q     <= '0;
      timer_q      <= '0;
      seq_q        <= '0;
      env_start_q  <= 1'b0;
      env_div_q    <= '0;
      decay_q      <= '0;
      length_q     <= '0;
      swp_div_q    <= '0;
      swp_reload_q <= 1'b0;
      pulse_q      <= '0;
      active_q     <= 1'b0;
    end else begin
      duty_q       <= duty_d;
      halt_q       <= halt_d;
      const_q      <= const_d;
      vol_q        <= vol_d;
      swp_en_q     <= swp_en_d;
      swp_per_q    <= swp_per_d;
      negate_q     <= negate_d;
      shift_q      <= shift_d;
      period_q     <= period_d;
      timer_q      <= timer_d;
      seq_q        <= seq_d;
      env_start_q  <= env_start_d;
      env_div_q    <= env_div_d;
      decay_q      <= decay_d;
      length_q     <= length_d;
      swp_div_q    <= swp_div_d;
      swp_reload_q <= swp_reload_d;
      pulse_q      <= pulse_d;
      active_q     <= active_d;
    end
  end

  assign pif.pulse_out = pulse_q;
  assign pif.active    = active_q;

endmodule
